// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator: word-wide big-endian memory, sub-word stores as read-modify-write; `LSU_PERF_CNT_EN adds load/store counters.
// Latency: error 0, word store 1, load / sub-word store 2 edges after acceptance; req is ignored (not queued) while busy.
module mem_access_ctrl #(
  parameter int MEM_BYTES = 256
`ifdef LSU_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqSigned,
  input  logic [31:0]       reqAddr,
  input  logic [31:0]       reqData,
  input  logic [31:0]       readData,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [31:0]       address,
  output logic [31:0]       writeData,
  output logic              memRead,
  output logic              memWrite
`ifdef LSU_PERF_CNT_EN
  , output logic [CNT_W-1:0] loadCount
  , output logic [CNT_W-1:0] storeCount
`endif
);

  typedef enum logic [2:0] {IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_WR} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d, signed_q, signed_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d, err_q, err_d;

  logic [32:0] size_m1, last_byte;
  logic        acc_err;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] load_val, merged;

  // Last touched byte is computed in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    case (reqSize)
      2'b00:   size_m1 = 33'd0;
      2'b01:   size_m1 = 33'd1;
      default: size_m1 = 33'd3;
    endcase
    last_byte = {1'b0, reqAddr} + size_m1;
    acc_err   = (reqSize == 2'b11)
             || (reqSize == 2'b01 && reqAddr[0])
             || (reqSize == 2'b10 && reqAddr[1:0] != 2'b00)
             || (last_byte >= 33'(MEM_BYTES));
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane8 = readData[31:24];
      2'd1:    lane8 = readData[23:16];
      2'd2:    lane8 = readData[15:8];
      default: lane8 = readData[7:0];
    endcase
    lane16 = addr_q[1] ? readData[15:0] : readData[31:16];
    case (size_q)
      2'b00:   load_val = {{24{signed_q & lane8[7]}}, lane8};
      2'b01:   load_val = {{16{signed_q & lane16[15]}}, lane16};
      default: load_val = readData;
    endcase
  end

  always_comb begin
    merged = readData;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[31:24] = data_q[7:0];
        2'd1:    merged[23:16] = data_q[7:0];
        2'd2:    merged[15:8]  = data_q[7:0];
        default: merged[7:0]   = data_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[15:0] = data_q[15:0];
    end else begin
      merged[31:16] = data_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          write_d  = reqWrite;
          size_d   = reqSize;
          signed_d = reqSigned;
          addr_d   = reqAddr;
          data_d   = reqData;
          if (acc_err) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (!reqWrite) begin
            state_d = LD_RD;
          end else if (reqSize == 2'b10) begin
            state_d = ST_WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LD_RD:  state_d = LD_CAP;
      LD_CAP: begin
        rdata_d = load_val;
        done_d  = 1'b1;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      RMW_RD: state_d = RMW_WR;
      ST_WR, RMW_WR: begin
        done_d  = 1'b1;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      rdata_q  <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign address   = {addr_q[31:2], 2'b00};
  assign writeData = (state_q == RMW_WR) ? merged : data_q;
  assign memRead   = (state_q == LD_RD) || (state_q == RMW_RD);
  assign memWrite  = (state_q == ST_WR) || (state_q == RMW_WR);

`ifdef LSU_PERF_CNT_EN
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d, store_cnt_q, store_cnt_d;

  // Only completing (non-error) requests count; both saturate at all-ones.
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (state_q == LD_CAP && load_cnt_q != '1)
      load_cnt_d = load_cnt_q + 1'b1;
    if ((state_q == ST_WR || state_q == RMW_WR) && store_cnt_q != '1)
      store_cnt_d = store_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign loadCount  = load_cnt_q;
  assign storeCount = store_cnt_q;
`endif

  // write_q is kept for debug visibility of the in-flight request type.
  logic unused_ok;
  assign unused_ok = write_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store initiator for the MEM pipeline stage. It takes one request at a time from the pipeline and drives the byte-addressed, big-endian, synchronous data memory.
- Memory read/write ports are word-wide only. Byte and halfword stores are done as read-modify-write; sub-word loads are lane-extracted with optional sign extension.
- Reports a done pulse, load data and an error flag back to the pipeline.

Parameters:
- MEM_BYTES, 256, memory size in bytes; any access touching a byte at or above MEM_BYTES is an error.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req  in  1  request strobe; sampled only while busy=0
- reqWrite  in  1  1=store, 0=load
- reqSize  in  2  00=byte, 01=halfword, 10=word; 11 is an error
- reqSigned  in  1  loads only: sign-extend sub-word result
- reqAddr  in  32  byte address
- reqData  in  32  store data, right-justified
- busy  out  1  request in flight; req ignored
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned, out-of-range or bad size
- rdata  out  32  load result, valid with done
- address  out  32  memory address, always {addr[31:2],2'b00}
- writeData  out  32  memory write word
- memRead  out  1  memory read enable
- memWrite  out  1  memory write enable

Behaviour:
- Reset: asynchronous. State=IDLE; busy, done, err, memRead, memWrite=0; rdata=0.
- Memory model: memory samples memRead/memWrite on a rising edge. readData is valid after that edge. Big-endian: byte offset k occupies bits [31-8k -: 8].
- Acceptance: in IDLE with req=1, all req* fields are latched at that edge (E0). Later changes to req* are ignored. req while busy=1 is dropped, not queued.
- Error check at acceptance. err is raised if any of:
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - reqSize=11
  - last byte address >= MEM_BYTES
- Error response: done=1 and err=1 from E0. State stays IDLE. No memRead/memWrite is issued.
- States: IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_WR.
- memRead, memWrite, address and writeData are combinational decodes of state and the latched request:
  - memRead=1 only in LD_RD and RMW_RD.
  - memWrite=1 only in ST_WR and RMW_WR.
- Load: IDLE -> LD_RD -> LD_CAP -> IDLE.
  - In LD_CAP, the lane is extracted from readData. Zero- or sign-extended per reqSigned; word loads are passed through.
  - rdata and done are registered at E2, so done is high in the cycle after E2.
- Word store: IDLE -> ST_WR -> IDLE. Memory is written at E1; done is set at E1.
- Sub-word store: IDLE -> RMW_RD -> RMW_WR -> IDLE.
  - writeData = readData with the target byte/halfword lane replaced by reqData[7:0] or reqData[15:0].
  - Memory is written at E2; done is set at E2.
- Outputs:
  - busy = (state != IDLE).
  - done is a single-cycle pulse.
  - rdata holds its value until the next load completes.
  - Stores leave rdata unchanged.
  - err is cleared on every non-error done.
- Back-to-back: a new req may be accepted in the same cycle done is high.
- Reset mid-operation: state returns to IDLE immediately and memWrite drops.
  - If reset asserts before the write edge, memory is not modified.
  - No done is issued for the aborted request.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- When defined:
  - Adds outputs loadCount and storeCount, each CNT_W wide.
  - Each increments on a non-error done for its request type and saturates at all-ones.
  - Both are cleared by reset.
- When undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 -> memWrite for exactly 1 cycle; rdata=0xDEADBEEF; err=0; load done 2 edges after acceptance.
- Byte store 0x55 to 0x13 after the above, then word load from 0x10 -> one memRead then one memWrite with writeData=0xDEADBE55; load returns 0xDEADBE55.
- Byte load from 0x10 -> signed gives rdata=0xFFFFFFDE; unsigned gives 0x000000DE. Halfword load from 0x12, signed -> 0xFFFFBE55.
- Halfword load at 0x11 and word store at 0xFE -> done=1, err=1 in the acceptance cycle; memRead/memWrite never asserted; memory unchanged.
- Reset during RMW_RD of a byte store to 0x10 -> memWrite never asserts, no done pulse; a later word load from 0x10 returns 0xDEADBE55.
- req held continuously over a load then a store -> the second request is accepted only in the done cycle of the first. With LSU_PERF_CNT_EN defined, loadCount=1 and storeCount=1.
